// File: rtl/hx8352_bus_responder.sv
// Target-side responder for the HX8352 8080-style bus: synchronizes the pins, decodes index and
// parameter cycles, keeps the window registers and GRAM cursor. HX8352_RESP_STATS_EN adds a pixel counter.
module hx8352_bus_responder #(
    parameter int         H_RES       = 240,
    parameter int         V_RES       = 400,
    parameter logic [7:0] CHIP_ID     = 8'h52,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_cs_n,
    input  logic        lcd_rs,
    input  logic        lcd_wr_n,
    input  logic        lcd_rd_n,
    input  logic        lcd_rst_n,
    input  logic [15:0] data_bus_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    output logic [7:0]  index_out,
    output logic        pix_valid,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        reg_strobe,
    output logic        bus_err,
    output logic [31:0] pixel_count
);
    localparam int          S      = SYNC_STAGES;
    localparam logic [15:0] H_LAST = 16'(H_RES - 1);
    localparam logic [15:0] V_LAST = 16'(V_RES - 1);

    logic [S-1:0]       cs_sync_r, rs_sync_r, wr_sync_r, rd_sync_r, rstn_sync_r;
    logic [S-1:0][15:0] data_sync_r;
    logic               cs_s, rs_s, wr_s, rd_s, int_rst_s, settled_s;
    logic               wr_rise_s, wr_fall_s, both_low_s, err_s, wr_evt_s;
    logic [15:0]        data_s;
    logic [S:0]         flush_r;
    logic               wr_d_r, armed_r, viol_r;
    logic               p1_wr_r, p1_err_r, p1_rs_r, rd_act_r;
    logic [15:0]        p1_data_r;
    logic               p2_idx_r, p2_param_r, p2_gram_r, p2_err_r;
    logic [15:0]        p2_data_r;
    logic [7:0]         win_r [8];
    logic [8:0]         x_r, y_r, x_nxt_s, y_nxt_s;
    logic [8:0]         col_start_s, col_end_s, row_start_s, row_end_s;
    logic [2:0]         widx_s;
    logic               in_win_s;
    logic [15:0]        rd_mux_s;

    // Pin synchronizers; active-low pins idle at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_r   <= {S{1'b1}};
            rs_sync_r   <= {S{1'b0}};
            wr_sync_r   <= {S{1'b1}};
            rd_sync_r   <= {S{1'b1}};
            rstn_sync_r <= {S{1'b1}};
            data_sync_r <= {S{16'h0000}};
        end else begin
            cs_sync_r   <= {cs_sync_r[S-2:0], lcd_cs_n};
            rs_sync_r   <= {rs_sync_r[S-2:0], lcd_rs};
            wr_sync_r   <= {wr_sync_r[S-2:0], lcd_wr_n};
            rd_sync_r   <= {rd_sync_r[S-2:0], lcd_rd_n};
            rstn_sync_r <= {rstn_sync_r[S-2:0], lcd_rst_n};
            data_sync_r <= {data_sync_r[S-2:0], data_bus_in};
        end
    end

    assign cs_s      = cs_sync_r[S-1];
    assign rs_s      = rs_sync_r[S-1];
    assign wr_s      = wr_sync_r[S-1];
    assign rd_s      = rd_sync_r[S-1];
    assign data_s    = data_sync_r[S-1];
    assign int_rst_s = rst | ~rstn_sync_r[S-1];
    // Edges are ignored until the synchronizer and wr_d_r hold real pin samples after a reset.
    assign settled_s  = (flush_r == {(S+1){1'b0}});
    assign wr_rise_s  = settled_s & wr_s & ~wr_d_r;
    assign wr_fall_s  = settled_s & ~wr_s & wr_d_r;
    assign both_low_s = settled_s & ~cs_s & ~rd_s & ~wr_s;
    assign err_s      = ~viol_r & ~cs_s & (both_low_s | (wr_rise_s & ~rd_s));
    assign wr_evt_s   = wr_rise_s & armed_r & ~viol_r & ~cs_s & rd_s;

    // Edge detection, write arming and one-shot protocol-violation tracking.
    always_ff @(posedge clk) begin
        if (int_rst_s) begin
            flush_r <= {(S+1){1'b1}};
            wr_d_r  <= 1'b1;
            armed_r <= 1'b0;
            viol_r  <= 1'b0;
        end else begin
            flush_r <= {1'b0, flush_r[S:1]};
            wr_d_r  <= wr_s;
            if (wr_fall_s)      armed_r <= 1'b1;
            else if (wr_rise_s) armed_r <= 1'b0;
            else                armed_r <= armed_r;
            if (err_s)              viol_r <= 1'b1;
            else if (wr_s && rd_s)  viol_r <= 1'b0;
            else                    viol_r <= viol_r;
        end
    end

    // Event capture followed by cycle-type decode.
    always_ff @(posedge clk) begin
        if (int_rst_s) begin
            p1_wr_r <= 1'b0;  p1_err_r <= 1'b0;  p1_rs_r <= 1'b0;  p1_data_r <= 16'h0000;
            rd_act_r <= 1'b0;
            p2_idx_r <= 1'b0; p2_param_r <= 1'b0; p2_gram_r <= 1'b0; p2_err_r <= 1'b0;
            p2_data_r <= 16'h0000;
        end else begin
            p1_wr_r    <= wr_evt_s;
            p1_err_r   <= err_s;
            p1_rs_r    <= rs_s;
            p1_data_r  <= data_s;
            rd_act_r   <= ~cs_s & ~rd_s;
            p2_idx_r   <= p1_wr_r & ~p1_rs_r;
            p2_param_r <= p1_wr_r & p1_rs_r & (index_out != 8'h22);
            p2_gram_r  <= p1_wr_r & p1_rs_r & (index_out == 8'h22);
            p2_err_r   <= p1_err_r;
            p2_data_r  <= p1_data_r;
        end
    end

    assign col_start_s = {win_r[0][0], win_r[1]};
    assign col_end_s   = {win_r[2][0], win_r[3]};
    assign row_start_s = {win_r[4][0], win_r[5]};
    assign row_end_s   = {win_r[6][0], win_r[7]};
    assign widx_s      = 3'(index_out[3:0] - 4'd2);
    assign in_win_s    = (index_out >= 8'h02) && (index_out <= 8'h09);

    // Cursor advance: wrap at the window end or at the array edge, whichever comes first.
    always_comb begin
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        if ((x_r == col_end_s) || (x_r == H_LAST[8:0])) begin
            x_nxt_s = col_start_s;
            if ((y_r == row_end_s) || (y_r == V_LAST[8:0])) y_nxt_s = row_start_s;
            else                                             y_nxt_s = y_r + 9'd1;
        end else begin
            x_nxt_s = x_r + 9'd1;
        end
    end

    // Read-back multiplexer.
    always_comb begin
        rd_mux_s = 16'h0000;
        case (index_out)
            8'h00:   rd_mux_s = {8'h00, CHIP_ID};
            default: begin
                if (in_win_s) rd_mux_s = {8'h00, win_r[widx_s]};
                else          rd_mux_s = 16'h0000;
            end
        endcase
    end

    // Architectural state and registered outputs.
    always_ff @(posedge clk) begin
        if (int_rst_s) begin
            index_out  <= 8'h00;
            x_r        <= 9'd0;
            y_r        <= 9'd0;
            win_r[0]   <= 8'h00;           win_r[1] <= 8'h00;
            win_r[2]   <= H_LAST[15:8];    win_r[3] <= H_LAST[7:0];
            win_r[4]   <= 8'h00;           win_r[5] <= 8'h00;
            win_r[6]   <= V_LAST[15:8];    win_r[7] <= V_LAST[7:0];
            data_out   <= 16'h0000;
            data_oe    <= 1'b0;
            pix_valid  <= 1'b0;
            pix_x      <= 9'd0;
            pix_y      <= 9'd0;
            pix_data   <= 16'h0000;
            reg_strobe <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            pix_valid  <= p2_gram_r;
            reg_strobe <= p2_param_r;
            bus_err    <= p2_err_r;
            data_oe    <= rd_act_r;
            if (rd_act_r) data_out <= rd_mux_s;
            if (p2_idx_r) begin
                index_out <= p2_data_r[7:0];
                if (p2_data_r[7:0] == 8'h22) begin
                    x_r <= col_start_s;
                    y_r <= row_start_s;
                end
            end
            if (p2_param_r && in_win_s) win_r[widx_s] <= p2_data_r[7:0];
            if (p2_gram_r) begin
                pix_x    <= x_r;
                pix_y    <= y_r;
                pix_data <= p2_data_r;
                x_r      <= x_nxt_s;
                y_r      <= y_nxt_s;
            end
        end
    end

`ifdef HX8352_RESP_STATS_EN
    logic [31:0] pix_cnt_r;

    // Pixel statistics, restarted whenever a new GRAM burst is opened.
    always_ff @(posedge clk) begin
        if (int_rst_s)                                  pix_cnt_r <= 32'h0;
        else if (p2_idx_r && (p2_data_r[7:0] == 8'h22)) pix_cnt_r <= 32'h0;
        else if (p2_gram_r)                             pix_cnt_r <= pix_cnt_r + 32'd1;
        else                                            pix_cnt_r <= pix_cnt_r;
    end
    assign pixel_count = pix_cnt_r;
`else
    assign pixel_count = 32'h0;
`endif

endmodule
